dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Data-memory access unit sitting directly downstream of the stack-instruction unit in dsd_processor. It arbitrates between stack-sequenced accesses (PUSH/POP beats) and ordinary load/store requests, and drives the single-port synchronous data memory. It tracks outstanding reads through a read-latency tag pipeline, then returns read data as aligned register-file or PC write-backs. It also flags out-of-range addresses.

## Interface
- RD_LAT, 1, data-memory read latency in cycles (legal 1..3)
- ADDR_LIMIT, 16'h1000, first illegal word address; addresses >= ADDR_LIMIT are out of range
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- st_mem_force  input  1  stack unit owns the memory this cycle
- st_dmem_wr  input  1  stack beat is a store (PUSH) when 1, load (POP) when 0
- st_dmem_addr  input  16  stack beat word address
- st_wdata  input  32  stack store data
- st_RF_wr  input  1  stack load writes the register file
- st_PC_wr  input  1  stack load writes the PC (POP {PC})
- st_rdest_addr  input  3  stack load destination register
- ls_req  input  1  load/store request; held until ls_ack
- ls_wr  input  1  1 = store, 0 = load
- ls_addr  input  16  load/store word address
- ls_wdata  input  32  store data
- ls_rdest  input  3  load destination register
- ls_ack  output  1  load/store request accepted this cycle
- stall  output  1  ls_req pending and not accepted
- mem_cs  output  1  memory chip select
- mem_we  output  1  memory write enable
- mem_addr  output  16  memory word address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid RD_LAT cycles after a read is issued
- wb_rf_en  output  1  register-file write-back strobe
- wb_pc_en  output  1  PC write-back strobe
- wb_addr  output  3  write-back register
- wb_data  output  32  write-back data
- err_oor  output  1  sticky out-of-range flag
- err_clr  input  1  clears err_oor

## Operation
- Arbitration is combinational each cycle.
  - st_mem_force=1: the stack beat is selected. ls_ack=0. stall=ls_req.
  - Otherwise, ls_req=1: the load/store is selected and ls_ack=1.
  - Otherwise: idle. mem_cs=0 and mem_we=0. mem_addr and mem_wdata hold their last value (don't-care).
- The selected request drives mem_addr, mem_wdata and mem_we in the same cycle.
- mem_cs=1 for any selected request with address < ADDR_LIMIT.
- An out-of-range request is handled as follows:
  - mem_cs=0 and mem_we=0.
  - err_oor is set on the next edge.
  - A load still enters the tag pipeline, with its data forced to 32'h0, so write-back order is preserved.
  - A store is dropped.
  - ls_ack is still asserted, so the pipeline cannot hang.
- Tag pipeline: RD_LAT stages. Each stage holds {valid, rf, pc, oor, rdest[2:0]}.
  - A read issued in cycle N enters stage 1 at the end of cycle N.
  - The tag reaches stage RD_LAT in cycle N+RD_LAT.
  - Stack loads take rf=st_RF_wr and pc=st_PC_wr.
  - LS loads take rf=1 and pc=0.
  - Stores and idle cycles insert valid=0.
- Write-back uses the final stage combinationally:
  - wb_rf_en = valid & rf
  - wb_pc_en = valid & pc
  - wb_addr = rdest
  - wb_data = oor ? 0 : mem_rdata
- A new tag enters the pipeline every cycle, giving back-to-back reads at full throughput.
- A store issued while reads are outstanding does not disturb their tags.
- Reads and writes to the same address are ordered by issue order. The memory resolves this; there is no forwarding.
- err_oor:
  - Set on an out-of-range access.
  - err_clr=1 clears it.
  - If set and clear occur in the same cycle, set wins.

## Timing
- Reset (asynchronous, resetn=0) forces:
  - All tag stages invalid.
  - err_oor=0.
  - mem_cs, mem_we, wb_rf_en, wb_pc_en, ls_ack and stall are 0 while reset is asserted.
- Reset asserted mid-operation discards all outstanding reads. No write-back follows reset release.
- Issue latency is 0 cycles (request to mem_cs). Read-to-write-back latency is exactly RD_LAT cycles.
- ls handshake:
  - The requester holds ls_req, ls_wr, ls_addr, ls_wdata and ls_rdest stable until the cycle ls_ack=1.
  - A transfer completes in the cycle where ls_req & ls_ack are both 1.
- Stack beats have no handshake. st_mem_force is honoured every cycle it is high.
- A multi-beat PUSH/POP stalls ls for its full duration.
- A POP of k registers produces k consecutive write-back cycles, starting RD_LAT cycles after the first beat.

## Test plan
- RD_LAT=1: ls load at addr 16'h0010, memory preloaded with 32'h1234_5678, rdest=3.
  - mem_cs=1 and mem_we=0 in cycle N.
  - In N+1: wb_rf_en=1, wb_addr=3, wb_data=32'h1234_5678.
- Collision: ls_req store held while st_mem_force is high for 3 POP beats (r0,r1,r2 from 16'h0FF0..0FF2).
  - stall=1 and ls_ack=0 for 3 cycles.
  - ls_ack=1 in the 4th cycle.
  - Write-backs for r0, r1 and r2 occur in consecutive cycles.
- POP {PC} with RD_LAT=2, st_PC_wr=1, st_RF_wr=0, memory word 32'h0000_0040.
  - Exactly 2 cycles later: wb_pc_en=1, wb_rf_en=0, wb_data=32'h40.
- Out of range: ls load at 16'h1000.
  - mem_cs=0.
  - err_oor=1 on the next edge.
  - wb_rf_en=1 with wb_data=0 after RD_LAT cycles.
  - err_clr then clears err_oor.
- Same-cycle set and clear: err_clr=1 in the same cycle as an out-of-range store → err_oor stays 1.
- Reset mid-read: deassert resetn one cycle after issuing a load with RD_LAT=3.
  - All outputs drop to 0.
  - After release, no write-back appears within 5 cycles.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: arbitrates stack beats vs load/store,
// drives the sync data memory, tracks reads, returns write-backs.
// Ports: stack beat (st_*), ls handshake (ls_*), memory (mem_*),
//        write-back (wb_*), sticky out-of-range flag (err_oor/err_clr).
module dmem_access_unit #(
  parameter int          RD_LAT     = 1,
  parameter logic [15:0] ADDR_LIMIT = 16'h1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_mem_force,
  input  logic        st_dmem_wr,
  input  logic [15:0] st_dmem_addr,
  input  logic [31:0] st_wdata,
  input  logic        st_RF_wr,
  input  logic        st_PC_wr,
  input  logic [2:0]  st_rdest_addr,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [15:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_rdest,
  output logic        ls_ack,
  output logic        stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        wb_rf_en,
  output logic        wb_pc_en,
  output logic [2:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err_oor,
  input  logic        err_clr
);

  typedef struct packed {
    logic       valid;
    logic       rf;
    logic       pc;
    logic       oor;
    logic [2:0] rdest;
  } tag_t;

  tag_t [RD_LAT-1:0] tag_q, tag_d;
  tag_t              tag_in, tag_out;

  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        sel_st, sel_ls, sel;
  logic        req_wr, req_oor;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;

  always_comb begin
    sel_st    = st_mem_force;
    sel_ls    = !st_mem_force && ls_req;
    sel       = sel_st || sel_ls;
    req_wr    = sel_st ? st_dmem_wr   : ls_wr;
    req_addr  = sel_st ? st_dmem_addr : ls_addr;
    req_wdata = sel_st ? st_wdata     : ls_wdata;
    req_oor   = sel && (req_addr >= ADDR_LIMIT);
  end

  // Combinational strobes are forced low while reset is held.
  always_comb begin
    ls_ack    = resetn && sel_ls;
    stall     = resetn && st_mem_force && ls_req;
    mem_cs    = resetn && sel && !req_oor;
    mem_we    = resetn && sel && !req_oor && req_wr;
    addr_d    = sel ? req_addr  : addr_q;
    wdata_d   = sel ? req_wdata : wdata_q;
    mem_addr  = addr_d;
    mem_wdata = wdata_d;
  end

  // Out-of-range loads still take a tag so write-back order holds.
  always_comb begin
    tag_in.valid = sel && !req_wr;
    tag_in.rf    = sel_st ? st_RF_wr : 1'b1;
    tag_in.pc    = sel_st ? st_PC_wr : 1'b0;
    tag_in.oor   = req_oor;
    tag_in.rdest = sel_st ? st_rdest_addr : ls_rdest;
    tag_d[0]     = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    tag_out = tag_q[RD_LAT-1];
  end

  always_comb begin
    wb_rf_en = tag_out.valid && tag_out.rf;
    wb_pc_en = tag_out.valid && tag_out.pc;
    wb_addr  = tag_out.rdest;
    wb_data  = tag_out.oor ? 32'h0 : mem_rdata;
  end

  // Set has priority over clear.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (req_oor) err_d = 1'b1;
    err_oor = err_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: three instances (RD_LAT 1..3)
// share stimulus and one behavioural sync memory.
module tb_dmem_access_unit;

  logic        clk, resetn;
  logic        st_mem_force, st_dmem_wr, st_RF_wr, st_PC_wr;
  logic [15:0] st_dmem_addr;
  logic [31:0] st_wdata;
  logic [2:0]  st_rdest_addr;
  logic        ls_req, ls_wr;
  logic [15:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [2:0]  ls_rdest;
  logic        err_clr;

  logic        a1_ack, a1_stall, a1_cs, a1_we, a1_rf, a1_pc, a1_err;
  logic        a2_ack, a2_stall, a2_cs, a2_we, a2_rf, a2_pc, a2_err;
  logic        a3_ack, a3_stall, a3_cs, a3_we, a3_rf, a3_pc, a3_err;
  logic [15:0] a1_maddr, a2_maddr, a3_maddr;
  logic [31:0] a1_mwd, a2_mwd, a3_mwd;
  logic [2:0]  a1_wba, a2_wba, a3_wba;
  logic [31:0] a1_wbd, a2_wbd, a3_wbd;

  logic [31:0] mem [0:8191];
  logic [31:0] pipe [0:2];

  int cmp = 0;
  int errs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a1_cs && a1_we) mem[a1_maddr[12:0]] <= a1_mwd;
    pipe[0] <= mem[a1_maddr[12:0]];
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  dmem_access_unit #(.RD_LAT(1)) u1 (
    .clk(clk), .resetn(resetn),
    .st_mem_force(st_mem_force), .st_dmem_wr(st_dmem_wr),
    .st_dmem_addr(st_dmem_addr), .st_wdata(st_wdata),
    .st_RF_wr(st_RF_wr), .st_PC_wr(st_PC_wr),
    .st_rdest_addr(st_rdest_addr),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdest(ls_rdest),
    .ls_ack(a1_ack), .stall(a1_stall),
    .mem_cs(a1_cs), .mem_we(a1_we), .mem_addr(a1_maddr),
    .mem_wdata(a1_mwd), .mem_rdata(pipe[0]),
    .wb_rf_en(a1_rf), .wb_pc_en(a1_pc), .wb_addr(a1_wba),
    .wb_data(a1_wbd), .err_oor(a1_err), .err_clr(err_clr));

  dmem_access_unit #(.RD_LAT(2)) u2 (
    .clk(clk), .resetn(resetn),
    .st_mem_force(st_mem_force), .st_dmem_wr(st_dmem_wr),
    .st_dmem_addr(st_dmem_addr), .st_wdata(st_wdata),
    .st_RF_wr(st_RF_wr), .st_PC_wr(st_PC_wr),
    .st_rdest_addr(st_rdest_addr),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdest(ls_rdest),
    .ls_ack(a2_ack), .stall(a2_stall),
    .mem_cs(a2_cs), .mem_we(a2_we), .mem_addr(a2_maddr),
    .mem_wdata(a2_mwd), .mem_rdata(pipe[1]),
    .wb_rf_en(a2_rf), .wb_pc_en(a2_pc), .wb_addr(a2_wba),
    .wb_data(a2_wbd), .err_oor(a2_err), .err_clr(err_clr));

  dmem_access_unit #(.RD_LAT(3)) u3 (
    .clk(clk), .resetn(resetn),
    .st_mem_force(st_mem_force), .st_dmem_wr(st_dmem_wr),
    .st_dmem_addr(st_dmem_addr), .st_wdata(st_wdata),
    .st_RF_wr(st_RF_wr), .st_PC_wr(st_PC_wr),
    .st_rdest_addr(st_rdest_addr),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdest(ls_rdest),
    .ls_ack(a3_ack), .stall(a3_stall),
    .mem_cs(a3_cs), .mem_we(a3_we), .mem_addr(a3_maddr),
    .mem_wdata(a3_mwd), .mem_rdata(pipe[2]),
    .wb_rf_en(a3_rf), .wb_pc_en(a3_pc), .wb_addr(a3_wba),
    .wb_data(a3_wbd), .err_oor(a3_err), .err_clr(err_clr));

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    st_mem_force = 0; st_dmem_wr = 0; st_dmem_addr = '0;
    st_wdata = '0; st_RF_wr = 0; st_PC_wr = 0; st_rdest_addr = '0;
    ls_req = 0; ls_wr = 0; ls_addr = '0; ls_wdata = '0;
    ls_rdest = '0; err_clr = 0;
  endtask

  task automatic test_reset();
    logic [20:0] o;
    resetn = 0;
    idle_inputs();
    st_mem_force = 1; ls_req = 1; st_dmem_addr = 16'h0010;
    #12;
    o = {a1_ack, a1_stall, a1_cs, a1_we, a1_rf, a1_pc, a1_err,
         a2_ack, a2_stall, a2_cs, a2_we, a2_rf, a2_pc, a2_err,
         a3_ack, a3_stall, a3_cs, a3_we, a3_rf, a3_pc, a3_err};
    cmp++;
    if (o !== 21'h0) begin
      errs++; $display("FAIL reset_outs got %h exp 0", o);
    end
    idle_inputs();
    next_cycle();
    resetn = 1;
    next_cycle();
    cmp++;
    if ({a1_rf, a2_rf, a3_rf, a1_err} !== 4'b0) begin
      errs++; $display("FAIL post_reset got %b exp 0000",
        {a1_rf, a2_rf, a3_rf, a1_err});
    end
  endtask

  task automatic test_load();
    ls_req = 1; ls_wr = 0; ls_addr = 16'h0010; ls_rdest = 3;
    #1;
    cmp++;
    if ({a1_cs, a1_we, a1_ack, a1_stall} !== 4'b1010) begin
      errs++; $display("FAIL ld_issue got %b exp 1010",
        {a1_cs, a1_we, a1_ack, a1_stall});
    end
    next_cycle();
    ls_req = 0;
    #1;
    cmp++;
    if ({a1_rf, a1_pc, a1_wba, a1_wbd} !== {2'b10, 3'd3, 32'h12345678}) begin
      errs++; $display("FAIL ld_wb1 got %b %b %0d %h exp 1 0 3 12345678",
        a1_rf, a1_pc, a1_wba, a1_wbd);
    end
    cmp++;
    if (a2_rf !== 1'b0) begin
      errs++; $display("FAIL ld_wb2_early got %b exp 0", a2_rf);
    end
    next_cycle();
    #1;
    cmp++;
    if ({a1_rf, a2_rf, a2_wba, a2_wbd} !== {2'b01, 3'd3, 32'h12345678}) begin
      errs++; $display("FAIL ld_wb2 got %b %b %0d %h exp 0 1 3 12345678",
        a1_rf, a2_rf, a2_wba, a2_wbd);
    end
    next_cycle();
    #1;
    cmp++;
    if ({a2_rf, a3_rf, a3_wba, a3_wbd} !== {2'b01, 3'd3, 32'h12345678}) begin
      errs++; $display("FAIL ld_wb3 got %b %b %0d %h exp 0 1 3 12345678",
        a2_rf, a3_rf, a3_wba, a3_wbd);
    end
    next_cycle();
  endtask

  task automatic test_collision();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA0A0_0000;
    exp_d[1] = 32'hA1A1_1111;
    exp_d[2] = 32'hA2A2_2222;
    ls_req = 1; ls_wr = 1; ls_addr = 16'h0020;
    ls_wdata = 32'hDEAD_BEEF; ls_rdest = 1;
    for (int i = 0; i < 3; i++) begin
      st_mem_force = 1; st_dmem_wr = 0; st_RF_wr = 1; st_PC_wr = 0;
      st_dmem_addr = 16'h0FF0 + 16'(i);
      st_rdest_addr = 3'(i);
      #1;
      cmp++;
      if ({a1_stall, a1_ack, a1_cs, a1_we} !== 4'b1010) begin
        errs++; $display("FAIL col_stall%0d got %b exp 1010", i,
          {a1_stall, a1_ack, a1_cs, a1_we});
      end
      cmp++;
      if ({a2_maddr, a3_maddr} !== {2{16'h0FF0 + 16'(i)}}) begin
        errs++; $display("FAIL col_addr%0d got %h %h exp %h", i,
          a2_maddr, a3_maddr, 16'h0FF0 + 16'(i));
      end
      if (i > 0) begin
        cmp++;
        if ({a1_rf, a1_wba, a1_wbd} !== {1'b1, 3'(i-1), exp_d[i-1]}) begin
          errs++; $display("FAIL col_wb%0d got %b %0d %h exp 1 %0d %h",
            i-1, a1_rf, a1_wba, a1_wbd, i-1, exp_d[i-1]);
        end
      end
      next_cycle();
    end
    st_mem_force = 0;
    #1;
    cmp++;
    if ({a1_stall, a1_ack, a1_cs, a1_we} !== 4'b0111) begin
      errs++; $display("FAIL col_ack got %b exp 0111",
        {a1_stall, a1_ack, a1_cs, a1_we});
    end
    cmp++;
    if ({a2_mwd, a3_mwd} !== {2{32'hDEAD_BEEF}}) begin
      errs++; $display("FAIL col_wdata got %h %h exp deadbeef",
        a2_mwd, a3_mwd);
    end
    cmp++;
    if ({a1_rf, a1_wba, a1_wbd} !== {1'b1, 3'd2, exp_d[2]}) begin
      errs++; $display("FAIL col_wb2 got %b %0d %h exp 1 2 %h",
        a1_rf, a1_wba, a1_wbd, exp_d[2]);
    end
    next_cycle();
    ls_req = 0;
    #1;
    cmp++;
    if ({a1_rf, mem[16'h0020]} !== {1'b0, 32'hDEAD_BEEF}) begin
      errs++; $display("FAIL col_store got %b %h exp 0 deadbeef",
        a1_rf, mem[16'h0020]);
    end
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_pop_pc();
    st_mem_force = 1; st_dmem_wr = 0; st_dmem_addr = 16'h0030;
    st_RF_wr = 0; st_PC_wr = 1; st_rdest_addr = 7;
    next_cycle();
    idle_inputs();
    #1;
    cmp++;
    if (a2_pc !== 1'b0) begin
      errs++; $display("FAIL pc_early got %b exp 0", a2_pc);
    end
    next_cycle();
    #1;
    cmp++;
    if ({a2_pc, a2_rf, a2_wbd} !== {2'b10, 32'h40}) begin
      errs++; $display("FAIL pc_wb got %b %b %h exp 1 0 00000040",
        a2_pc, a2_rf, a2_wbd);
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_oor();
    ls_req = 1; ls_wr = 0; ls_addr = 16'h1000; ls_rdest = 5;
    #1;
    cmp++;
    if ({a1_cs, a1_we, a1_ack, a1_err} !== 4'b0010) begin
      errs++; $display("FAIL oor_issue got %b exp 0010",
        {a1_cs, a1_we, a1_ack, a1_err});
    end
    next_cycle();
    ls_req = 0;
    #1;
    cmp++;
    if ({a1_err, a1_rf, a1_wba, a1_wbd} !== {2'b11, 3'd5, 32'h0}) begin
      errs++; $display("FAIL oor_wb1 got %b %b %0d %h exp 1 1 5 0",
        a1_err, a1_rf, a1_wba, a1_wbd);
    end
    err_clr = 1;
    next_cycle();
    err_clr = 0;
    #1;
    cmp++;
    if ({a1_err, a2_err, a2_rf, a2_wbd} !== {3'b001, 32'h0}) begin
      errs++; $display("FAIL oor_clr got %b %b %b %h exp 0 0 1 0",
        a1_err, a2_err, a2_rf, a2_wbd);
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_set_clr();
    ls_req = 1; ls_wr = 1; ls_addr = 16'h2000;
    ls_wdata = 32'h5555_AAAA; err_clr = 1;
    #1;
    cmp++;
    if ({a1_cs, a1_we, a1_ack} !== 3'b001) begin
      errs++; $display("FAIL sc_issue got %b exp 001",
        {a1_cs, a1_we, a1_ack});
    end
    next_cycle();
    idle_inputs();
    #1;
    cmp++;
    if ({a1_err, a3_err, a1_rf} !== 3'b110) begin
      errs++; $display("FAIL sc_setwins got %b exp 110",
        {a1_err, a3_err, a1_rf});
    end
    err_clr = 1;
    next_cycle();
    err_clr = 0;
    #1;
    cmp++;
    if (a1_err !== 1'b0) begin
      errs++; $display("FAIL sc_clr got %b exp 0", a1_err);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    ls_req = 1; ls_wr = 0; ls_addr = 16'h0010; ls_rdest = 4;
    next_cycle();
    idle_inputs();
    resetn = 0;
    #1;
    cmp++;
    if ({a3_rf, a3_pc, a3_cs, a3_ack, a2_rf, a1_rf} !== 6'b0) begin
      errs++; $display("FAIL rst_mid got %b exp 0",
        {a3_rf, a3_pc, a3_cs, a3_ack, a2_rf, a1_rf});
    end
    next_cycle();
    resetn = 1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      cmp++;
      if ({a1_rf, a2_rf, a3_rf, a3_pc} !== 4'b0) begin
        errs++; $display("FAIL rst_nowb%0d got %b exp 0000", i,
          {a1_rf, a2_rf, a3_rf, a3_pc});
      end
    end
  endtask

  initial begin
    mem[16'h0010] = 32'h1234_5678;
    mem[16'h0030] = 32'h0000_0040;
    mem[16'h0FF0] = 32'hA0A0_0000;
    mem[16'h0FF1] = 32'hA1A1_1111;
    mem[16'h0FF2] = 32'hA2A2_2222;
    test_reset();
    test_load();
    test_collision();
    test_pop_pc();
    test_oor();
    test_set_clr();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
